// File: rtl/keypad_event_queue.sv
// Debounces a 16-key one-hot vector and queues each new press as a 4-bit code,
// lowest index first, behind a show-ahead valid/ready FIFO.
module keypad_event_queue #(
   parameter int DEBOUNCE   = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [15:0]                   keys,
   output logic [3:0]                    key_code,
   output logic                          key_valid,
   input  logic                          key_ready,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int CW  = $clog2(DEBOUNCE + 1);
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int AW1 = AW + 1;
   localparam logic [CW-1:0]  CNT_MAX    = CW'(DEBOUNCE);
   localparam logic [CW-1:0]  CNT_COMMIT = CW'(DEBOUNCE - 1);
   localparam logic [AW:0]    FULL_COUNT = AW1'(FIFO_DEPTH);

   logic [15:0]   k_q_r;
   logic [CW-1:0] cnt_r;
   logic [15:0]   deb_r;
   logic [15:0]   pending_r;
   logic [3:0]    mem_r [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;

   logic          stable_s;
   logic          commit_s;
   logic          pop_s;
   logic          push_s;
   logic          drop_s;
   logic [3:0]    push_code_s;
   logic [15:0]   pending_next_s;
   logic [AW-1:0] rd_next_s;
   logic [AW:0]   count_next_s;

   function automatic logic [3:0] lowest_set(input logic [15:0] v);
      logic [3:0] idx;
      idx = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (v[i]) begin
            idx = 4'(i);
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

   // Debounce commit, one-per-edge encoder drain and FIFO bookkeeping decisions.
   always_comb begin
      stable_s       = (keys == k_q_r);
      commit_s       = stable_s && (cnt_r == CNT_COMMIT);
      pop_s          = key_valid && key_ready;
      push_code_s    = lowest_set(pending_r);
      pending_next_s = pending_r & (pending_r - 16'd1);
      push_s         = 1'b0;
      drop_s         = 1'b0;
      if (pending_r != 16'd0) begin
         if ((fifo_count != FULL_COUNT) || pop_s) begin
            push_s = 1'b1;
         end else begin
            drop_s = 1'b1;
         end
      end else begin
         push_s = 1'b0;
      end
      if (pop_s) begin
         rd_next_s = rd_ptr_r + AW'(1);
      end else begin
         rd_next_s = rd_ptr_r;
      end
      if (push_s && !pop_s) begin
         count_next_s = fifo_count + AW1'(1);
      end else if (pop_s && !push_s) begin
         count_next_s = fifo_count - AW1'(1);
      end else begin
         count_next_s = fifo_count;
      end
   end

   // State registers; key_code is re-registered from the head the FIFO will have after this edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         k_q_r      <= 16'd0;
         cnt_r      <= '0;
         deb_r      <= 16'd0;
         pending_r  <= 16'd0;
         wr_ptr_r   <= '0;
         rd_ptr_r   <= '0;
         key_valid  <= 1'b0;
         key_code   <= 4'd0;
         overflow   <= 1'b0;
         fifo_count <= '0;
      end else begin
         k_q_r <= keys;
         if (!stable_s) begin
            cnt_r <= '0;
         end else if (cnt_r != CNT_MAX) begin
            cnt_r <= cnt_r + CW'(1);
         end
         if (commit_s) begin
            deb_r     <= k_q_r;
            pending_r <= pending_next_s | (k_q_r & ~deb_r);
         end else begin
            pending_r <= pending_next_s;
         end
         if (push_s) begin
            mem_r[wr_ptr_r] <= push_code_s;
            wr_ptr_r        <= wr_ptr_r + AW'(1);
         end
         rd_ptr_r <= rd_next_s;
         if (drop_s) begin
            overflow <= 1'b1;
         end
         fifo_count <= count_next_s;
         key_valid  <= (count_next_s != '0);
         // A push lands at the head when the queue was empty, or held one entry that is popping.
         if (push_s && (rd_next_s == wr_ptr_r)) begin
            key_code <= push_code_s;
         end else if (count_next_s != '0) begin
            key_code <= mem_r[rd_next_s];
         end
      end
   end

endmodule

// File: tb/tb_keypad_event_queue.sv
// Directed bench for keypad_event_queue: a queue-based reference model checked
// every cycle, plus hand-computed expectations at the key moments.
module tb_keypad_event_queue;

   localparam int D     = 16;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] keys;
   logic [3:0]  key_code;
   logic        key_valid;
   logic        key_ready;
   logic        overflow;
   logic [2:0]  fifo_count;

   int checks   = 0;
   int failures = 0;

   keypad_event_queue #(.DEBOUNCE(D), .FIFO_DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .keys       (keys),
      .key_code   (key_code),
      .key_valid  (key_valid),
      .key_ready  (key_ready),
      .overflow   (overflow),
      .fifo_count (fifo_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: stable-run counter, set of accepted presses, event queue.
   bit          model_on = 1'b0;
   logic [15:0] m_prev;
   logic [15:0] m_deb;
   logic [15:0] m_pend;
   int          m_run;
   int          m_fifo[$];
   bit          m_ovf;

   // Advance the model by one clock edge using the inputs present at that edge.
   always @(posedge clk) begin : model
      int lo;
      if (rst) begin
         m_prev   = 16'd0;
         m_deb    = 16'd0;
         m_pend   = 16'd0;
         m_run    = 0;
         m_fifo   = {};
         m_ovf    = 1'b0;
         model_on = 1'b1;
      end else begin
         if (m_fifo.size() > 0 && key_ready) begin
            void'(m_fifo.pop_front());
         end
         if (m_pend != 16'd0) begin
            lo = 0;
            for (int b = 15; b >= 0; b--) begin
               if (m_pend[b]) lo = b;
            end
            m_pend[lo] = 1'b0;
            if (m_fifo.size() < DEPTH) m_fifo.push_back(lo);
            else m_ovf = 1'b1;
         end
         if (keys == m_prev) begin
            if (m_run == D - 1) begin
               m_pend = m_pend | (keys & ~m_deb);
               m_deb  = keys;
            end
            if (m_run < D) m_run++;
         end else begin
            m_run = 0;
         end
         m_prev = keys;
      end
   end

   // Compare DUT outputs against the model on every falling edge.
   always @(negedge clk) begin
      if (model_on) begin
         check("key_valid", int'(key_valid), int'(m_fifo.size() > 0));
         check("fifo_count", int'(fifo_count), m_fifo.size());
         check("overflow", int'(overflow), int'(m_ovf));
         if (m_fifo.size() > 0) check("key_code", int'(key_code), m_fifo[0]);
      end
   end

   task automatic edges(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pop_one();
      key_ready = 1'b1;
      edges(1);
      key_ready = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      keys      = 16'd0;
      key_ready = 1'b0;
      edges(2);
      rst = 1'b0;

      // Idle after reset
      edges(100);
      check("lit_idle_valid", int'(key_valid), 0);
      check("lit_idle_ovf", int'(overflow), 0);
      check("lit_idle_count", int'(fifo_count), 0);

      // Single clean press of key 5: visible right after E17
      keys = 16'h0020;
      edges(17);
      check("lit_single_e16_valid", int'(key_valid), 0);
      edges(1);
      check("lit_single_e17_valid", int'(key_valid), 1);
      check("lit_single_code", int'(key_code), 5);
      check("lit_single_count", int'(fifo_count), 1);
      edges(60);
      check("lit_single_hold_count", int'(fifo_count), 1);
      check("lit_single_hold_code", int'(key_code), 5);
      pop_one();
      check("lit_single_popped", int'(key_valid), 0);
      keys = 16'd0;
      edges(40);

      // Bounce on bit 3 every 10 cycles, then hold
      for (int t = 0; t < 20; t++) begin
         keys[3] = ~keys[3];
         edges(10);
      end
      check("lit_bounce_none", int'(fifo_count), 0);
      keys = 16'h0008;
      edges(17);
      check("lit_bounce_e16_valid", int'(key_valid), 0);
      edges(1);
      check("lit_bounce_valid", int'(key_valid), 1);
      check("lit_bounce_code", int'(key_code), 3);
      edges(60);
      check("lit_bounce_count", int'(fifo_count), 1);
      pop_one();
      keys = 16'd0;
      edges(40);

      // Chord 0,10,15 with the consumer always ready
      key_ready = 1'b1;
      keys      = 16'h8401;
      edges(17);
      check("lit_chord_e16_valid", int'(key_valid), 0);
      edges(1);
      check("lit_chord_code0", int'(key_code), 0);
      edges(1);
      check("lit_chord_code10", int'(key_code), 10);
      edges(1);
      check("lit_chord_code15", int'(key_code), 15);
      check("lit_chord_valid", int'(key_valid), 1);
      edges(1);
      check("lit_chord_empty", int'(key_valid), 0);
      key_ready = 1'b0;
      keys      = 16'd0;
      edges(40);

      // Full FIFO with push and pop on the same edge, then mid-run reset
      keys = 16'h000F;
      edges(25);
      check("lit_full_count", int'(fifo_count), 4);
      check("lit_full_head", int'(key_code), 0);
      keys = 16'h008F;
      edges(17);
      key_ready = 1'b1;
      edges(1);
      key_ready = 1'b0;
      check("lit_pp_count", int'(fifo_count), 4);
      check("lit_pp_ovf", int'(overflow), 0);
      check("lit_pp_head", int'(key_code), 1);
      rst  = 1'b1;
      keys = 16'h0080;
      edges(1);
      rst = 1'b0;
      check("lit_rst_valid", int'(key_valid), 0);
      check("lit_rst_count", int'(fifo_count), 0);
      edges(17);
      check("lit_rst_e16_valid", int'(key_valid), 0);
      edges(1);
      check("lit_rst_valid_again", int'(key_valid), 1);
      check("lit_rst_code", int'(key_code), 7);
      check("lit_rst_count_one", int'(fifo_count), 1);
      pop_one();
      keys = 16'd0;
      edges(40);

      // Overflow: six keys into a four-entry FIFO
      keys = 16'h003F;
      edges(30);
      check("lit_ovf_count", int'(fifo_count), 4);
      check("lit_ovf_flag", int'(overflow), 1);
      key_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("lit_ovf_code", int'(key_code), i);
         edges(1);
      end
      key_ready = 1'b0;
      check("lit_ovf_empty", int'(key_valid), 0);
      check("lit_ovf_sticky", int'(overflow), 1);
      keys = 16'd0;
      edges(20);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/keypad_event_queue.md
# keypad_event_queue

Consumes the 16-bit one-hot-per-key `keys` vector from the keypad column scanner and turns it into a stream of debounced key-press events. Each event is a 4-bit key code delivered over a valid/ready handshake. The block debounces the whole key vector and detects newly pressed keys. When several keys go down together, it serialises them lowest index first and buffers them in a small show-ahead FIFO. Downstream consumers (display/entry logic) read one key code per handshake and never see bounce or repeats while a key is held.

## Interface
- `DEBOUNCE`, 16: consecutive clock cycles `keys` must be unchanged before it is accepted; legal range 1..65535.
- `FIFO_DEPTH`, 4: event FIFO entries; power of two, at least 2.

- `clk`  input  1  system clock; all logic rises on posedge.
- `rst`  input  1  reset, synchronous, active-high.
- `keys`  input  16  raw key-down vector from the scanner; bit n = key code n pressed.
- `key_code`  output  4  code of the event at the FIFO head; valid only while `key_valid`=1.
- `key_valid`  output  1  FIFO non-empty.
- `key_ready`  input  1  consumer accepts the head event on an edge where `key_valid`=1.
- `overflow`  output  1  sticky; set when an event is dropped because the FIFO is full.
- `fifo_count`  output  log2(FIFO_DEPTH)+1  number of queued events.

## Operation
- Reset (edge with `rst`=1) sets the following to 0: `k_q` (the input sample register), `cnt`, `deb` (the debounced vector), `pending`, the FIFO pointers, `key_valid`, `key_code`, `overflow` and `fifo_count`. After reset every key is treated as released. A key already held at reset becomes one event once it is stable.
- Input sampling: `k_q <= keys` on every edge.
- Stability counter, evaluated on every edge:
  - If `keys != k_q`, then `cnt <= 0`.
  - Else if `cnt < DEBOUNCE`, then `cnt <= cnt+1`.
  - `cnt` saturates at DEBOUNCE.
- Debounce commit: on an edge where `keys == k_q` and `cnt == DEBOUNCE-1`, do both `deb <= k_q` and `pending <= pending_next | (k_q & ~deb)`. The term `k_q & ~deb` is the set of new presses. Releases only clear `deb` bits and generate no event.
- Encoder/drain: one item per edge.
  - If `pending` is non-zero, take its lowest set bit i, clear bit i (this is `pending_next`) and push code i.
  - If the FIFO is full and no pop happens on that edge, drop the code, still clear bit i, and set `overflow`.
- FIFO: show-ahead, so `key_code` always reflects the head entry.
  - Pop when `key_valid & key_ready`.
  - Push and pop on the same edge are both honoured, including when the FIFO is full or holds one entry. `fifo_count` is unchanged in that case.
  - Pointers wrap modulo FIFO_DEPTH.
- Holding a key never generates a second event. Release must be debounced into `deb` before a re-press counts.
- A key whose bit is in `pending` but is released before draining is still emitted, because the press was already accepted.
- `rst` asserted mid-operation discards `pending` and all FIFO contents on that edge.

## Timing
- Let E0 be the first edge that samples a new stable value V, so `k_q` becomes V at E0 and `cnt` becomes 0.
- `cnt` reaches k at edge Ek. `deb` and `pending` update at E(DEBOUNCE).
- The FIFO push happens at E(DEBOUNCE+1). `key_valid`=1 and `key_code` are valid immediately after that edge, provided the FIFO was empty and pending was empty.
- Any change of `keys` before E(DEBOUNCE) restarts the count, and no event is produced.
- N simultaneous new presses enter the FIFO on N consecutive edges, in ascending code order.
- `key_valid` and `key_code` are registered or pointer-derived, with no combinational path from `key_ready`.
- `key_valid` and `key_code` stay stable until popped.
- Throughput is at most one event per clock in each direction.

## Test plan
- Reset then idle: hold `rst` for 2 edges with `keys`=0. Expect `key_valid`=0, `overflow`=0, `fifo_count`=0 for 100 cycles.
- Single clean press, DEBOUNCE=16: set `keys`=16'h0020 and hold it, with `key_ready`=0. Expect `key_valid` to rise after E17 with `key_code`=5 and `fifo_count`=1. It stays that way indefinitely and there is no second event while the key is held.
- Bounce rejection: toggle bit 3 every 10 cycles for 200 cycles, then hold it high. Expect exactly one event, code 3, first visible after E17 of the final stable period.
- Chord ordering: change `keys` from 0 to 16'h8401 with `key_ready`=1. Expect codes 0, 10, 15 on three consecutive handshakes.
- Overflow, FIFO_DEPTH=4 with `key_ready`=0: press 6 keys together (16'h003F). Expect the FIFO to hold 0,1,2,3, with `fifo_count`=4 and `overflow`=1. After 4 pops the FIFO is empty and `overflow` still reads 1.
- Full with simultaneous push/pop and mid-run reset:
  - Start with the FIFO full and one pending code 7, then assert `key_ready` for one edge. Expect the head to pop, 7 to be pushed, `fifo_count` to stay at 4 and `overflow` to stay 0.
  - Then assert `rst` for one edge. Expect everything to clear; a still-held key yields one new event after DEBOUNCE+2 edges.
